sort_job_seq: RTL and testbench
===============================

SORT_JOB_SEQ -- requirements
Module: sort_job_seq

Interface
REQ-001 The block SHALL have parameter MM, default 256, meaning the sort memory depth in words.
REQ-002 The block SHALL have parameter MN, default 32, meaning the element width in bits.
REQ-003 The block SHALL have parameter MW, default 8, meaning log2(MM).
REQ-004 The block SHALL have parameter MEM_BASE, default 32'h0000_0000, meaning the sort-memory word 0 byte address.
REQ-005 The block SHALL have parameter NUM_ADDR, default 32'h0000_0400, meaning the element-count register.
REQ-006 The block SHALL have parameter START_ADDR, default 32'h0000_0404, meaning the start register.
REQ-007 The block SHALL have parameter STATUS_ADDR, default 32'h0000_0408, meaning the status register (bit0 busy, bit1 error).
REQ-008 The block SHALL have parameter POLL_LIMIT, default 65535, meaning the maximum status polls per job.
REQ-009 clk  in  1  clock; reset_n  in  1  reset, asynchronous, active-low.
REQ-010 job_start  in  1  single-cycle request to run one job; job_num  in  MW+1  element count, sampled with job_start.
REQ-011 in_valid  in  1 / in_ready  out  1 / in_data  in  MN  unsorted element stream.
REQ-012 out_valid  out  1 / out_ready  in  1 / out_data  out  MN  sorted element stream.
REQ-013 job_busy  out  1  job in progress; job_done  out  1  one-cycle completion pulse; job_err  out  1  error flag of the last job.
REQ-014 En  out  1 / Wr  out  1 / Addr  out  32 / WrData  out  32  sort engine host bus; Data  in  32  read data, valid exactly one cycle after a read (En=1, Wr=0).

Function
REQ-015 The FSM states SHALL be IDLE, LOAD, WNUM, WSTART, POLL_RD, POLL_CHK, UNLOAD_RD, UNLOAD_CAP, UNLOAD_OUT, DONE.
REQ-016 In IDLE, job_start SHALL latch job_num into cnt_total, clear idx, and go to LOAD; if job_num==0 or job_num>MM, it SHALL instead go to DONE with the error set and no bus traffic.
REQ-017 job_start outside IDLE SHALL be ignored.
REQ-018 In LOAD, in_ready=1; each in_valid&in_ready cycle SHALL drive En=1, Wr=1, Addr=MEM_BASE+{idx,2'b00}, WrData=zero-extended in_data, and increment idx. After idx reaches cnt_total, the FSM SHALL go to WNUM.
REQ-019 WNUM SHALL write cnt_total to NUM_ADDR for one cycle; WSTART SHALL then write 32'h1 to START_ADDR for one cycle; the FSM SHALL then go to POLL_RD.
REQ-020 POLL_RD SHALL issue one read of STATUS_ADDR. POLL_CHK SHALL sample Data: if bit0=1, go back to POLL_RD; if bit0=0 and bit1=1, go to DONE with the error set; otherwise clear idx and go to UNLOAD_RD.
REQ-021 UNLOAD_RD SHALL read MEM_BASE+{idx,2'b00}. UNLOAD_CAP SHALL register Data[MN-1:0] into out_data and set out_valid.
REQ-022 UNLOAD_OUT SHALL hold out_valid and out_data stable until out_ready; on handshake it SHALL increment idx and go to UNLOAD_RD, or to DONE once idx reaches cnt_total.
REQ-023 Only one bus read SHALL be outstanding at a time; En SHALL be 0 in every state and cycle not named above.
REQ-024 DONE SHALL pulse job_done for exactly one cycle and return to IDLE.
REQ-025 job_err SHALL update on entry to DONE and hold until the next accepted job_start, which clears it.
REQ-026 job_busy SHALL be 1 in every state except IDLE.
REQ-027 An error job SHALL produce no output stream.

Reset
REQ-028 Asserting reset_n low SHALL force IDLE asynchronously, including mid-job, with all outputs 0 (En, Wr, Addr, WrData, in_ready, out_valid, out_data, job_busy, job_done, job_err) and idx/cnt_total cleared.
REQ-029 After reset, the block SHALL accept no partial job; the engine is reset by the same reset_n.

Configuration
REQ-030 With macro SORT_SEQ_TIMEOUT_EN defined, a poll counter SHALL count POLL_RD entries per job; reaching POLL_LIMIT SHALL go to DONE with job_err=1 and no output stream.
REQ-031 Without SORT_SEQ_TIMEOUT_EN, no counter SHALL exist and polling SHALL continue indefinitely.

Verification
REQ-032 Scenario: job_num=4, inputs 9,3,7,1 with continuous valid -> 4 writes to 0x0,0x4,0x8,0xC; NUM write=4; START write=1; outputs 1,3,7,9; one job_done pulse; job_err=0.
REQ-033 Scenario: job_num=0, then job_num=257 -> each gives job_done one cycle after acceptance with job_err=1, and En stays 0.
REQ-034 Scenario: job_num=3, out_ready toggled 0/1 randomly -> out_data held stable while out_valid&!out_ready; no duplicate or lost elements; reads never overlap.
REQ-035 Scenario: status model returns 2'b10 after busy -> job_err=1, no out_valid, job_done pulse.
REQ-036 Scenario: reset_n pulsed low during POLL_CHK -> all outputs 0 immediately; a new job_num=2 job completes correctly.
REQ-037 Scenario: SORT_SEQ_TIMEOUT_EN defined, POLL_LIMIT=8, status stuck busy -> exactly 8 status reads, then job_err=1 and job_done.

Source files
------------

// File: rtl/sort_job_seq.sv
// sort_job_seq: runs one sort job over the engine host bus (load, start, poll, unload); SORT_SEQ_TIMEOUT_EN adds a poll timeout
module sort_job_seq #(
    parameter int          MM          = 256,
    parameter int          MN          = 32,
    parameter int          MW          = 8,
    parameter logic [31:0] MEM_BASE    = 32'h0000_0000,
    parameter logic [31:0] NUM_ADDR    = 32'h0000_0400,
    parameter logic [31:0] START_ADDR  = 32'h0000_0404,
    parameter logic [31:0] STATUS_ADDR = 32'h0000_0408,
    parameter int          POLL_LIMIT  = 65535
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          job_start,
    input  logic [MW:0]   job_num,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [MN-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MN-1:0] out_data,
    output logic          job_busy,
    output logic          job_done,
    output logic          job_err,
    output logic          En,
    output logic          Wr,
    output logic [31:0]   Addr,
    output logic [31:0]   WrData,
    input  logic [31:0]   Data
);
    localparam logic [3:0] IDLE       = 4'd0;
    localparam logic [3:0] LOAD       = 4'd1;
    localparam logic [3:0] WNUM       = 4'd2;
    localparam logic [3:0] WSTART     = 4'd3;
    localparam logic [3:0] POLL_RD    = 4'd4;
    localparam logic [3:0] POLL_CHK   = 4'd5;
    localparam logic [3:0] UNLOAD_RD  = 4'd6;
    localparam logic [3:0] UNLOAD_CAP = 4'd7;
    localparam logic [3:0] UNLOAD_OUT = 4'd8;
    localparam logic [3:0] DONE       = 4'd9;

    logic [3:0]    state_q, state_d;
    logic [MW:0]   idx_q, idx_d, cnt_q, cnt_d;
    logic [MN-1:0] out_data_q, out_data_d;
    logic          err_q, err_d;
    logic [MW:0]   idx_inc;
    logic [31:0]   mem_addr;
    logic          bad_num, load_wr, timeout;

    assign idx_inc  = idx_q + (MW+1)'(1);
    assign mem_addr = MEM_BASE + (32'(idx_q) << 2);
    assign bad_num  = job_num == '0 || 32'(job_num) > MM;
    assign load_wr  = state_q == LOAD && in_valid;

`ifdef SORT_SEQ_TIMEOUT_EN
    logic [31:0] poll_q, poll_d;
    assign timeout = poll_q >= 32'(POLL_LIMIT);
    // poll counter restarts with each engine start and counts status reads
    always_comb poll_d = state_q == WSTART ? 32'h0 : state_q == POLL_RD ? poll_q + 32'h1 : poll_q;
    // poll counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) poll_q <= 32'h0;
        else          poll_q <= poll_d;
    end
`else
    assign timeout = 1'b0;
`endif

    assign in_ready  = state_q == LOAD;
    assign out_valid = state_q == UNLOAD_OUT;
    assign out_data  = out_data_q;
    assign job_busy  = state_q != IDLE;
    assign job_done  = state_q == DONE;
    assign job_err   = err_q;

    // host bus decode: only bus-owning states drive En, everything else idles at zero
    always_comb begin
        En     = load_wr || state_q == WNUM || state_q == WSTART || state_q == POLL_RD || state_q == UNLOAD_RD;
        Wr     = load_wr || state_q == WNUM || state_q == WSTART;
        Addr   = load_wr || state_q == UNLOAD_RD ? mem_addr :
                 state_q == WNUM ? NUM_ADDR : state_q == WSTART ? START_ADDR :
                 state_q == POLL_RD ? STATUS_ADDR : 32'h0;
        WrData = load_wr ? 32'(in_data) : state_q == WNUM ? 32'(cnt_q) : state_q == WSTART ? 32'h1 : 32'h0;
    end

    // job sequencing; read data is consumed in the cycle after each read
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        out_data_d = out_data_q;
        case (state_q)
            IDLE: if (job_start) begin
                cnt_d   = job_num;
                idx_d   = '0;
                err_d   = bad_num;
                state_d = bad_num ? DONE : LOAD;
            end
            LOAD: if (in_valid) begin
                idx_d   = idx_inc;
                state_d = idx_inc == cnt_q ? WNUM : LOAD;
            end
            WNUM:     state_d = WSTART;
            WSTART:   state_d = POLL_RD;
            POLL_RD:  state_d = POLL_CHK;
            POLL_CHK: begin
                state_d = Data[0] ? (timeout ? DONE : POLL_RD) : Data[1] ? DONE : UNLOAD_RD;
                err_d   = Data[0] ? timeout : Data[1];
                idx_d   = '0;
            end
            UNLOAD_RD:  state_d = UNLOAD_CAP;
            UNLOAD_CAP: begin
                out_data_d = Data[MN-1:0];
                state_d    = UNLOAD_OUT;
            end
            UNLOAD_OUT: if (out_ready) begin
                idx_d   = idx_inc;
                state_d = idx_inc == cnt_q ? DONE : UNLOAD_RD;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers, cleared asynchronously so a reset aborts any job
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            out_data_q <= out_data_d;
        end
    end
endmodule

// File: tb/tb_sort_job_seq.sv
// tb_sort_job_seq: random jobs against a behavioural sort engine and a sorted-queue reference
module tb_sort_job_seq;
    localparam logic [31:0] NUM_A  = 32'h400;
    localparam logic [31:0] STRT_A = 32'h404;
    localparam logic [31:0] STAT_A = 32'h408;

    logic        clk = 0, reset_n = 0, job_start = 0, in_valid = 0, out_ready = 1;
    logic [8:0]  job_num = 0;
    logic [31:0] in_data = 0, out_data, Addr, WrData, Data;
    logic        in_ready, out_valid, job_busy, job_done, job_err, En, Wr;

    always #5 clk = ~clk;

    sort_job_seq #(.POLL_LIMIT(8)) dut (
        .clk(clk), .reset_n(reset_n), .job_start(job_start), .job_num(job_num),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .job_busy(job_busy), .job_done(job_done), .job_err(job_err),
        .En(En), .Wr(Wr), .Addr(Addr), .WrData(WrData), .Data(Data)
    );

    int n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // behavioural sort engine: memory, count, start, status with configurable busy time
    logic [31:0] emem [256];
    logic [31:0] e_num;
    logic        e_sorted;
    int          e_busy;
    bit          stuck = 0, err_mode = 0, rnd_ready = 0;
    int          busy_len = 2;

    function automatic logic [31:0] kth(input int k);
        logic [31:0] t[$];
        for (int i = 0; i < int'(e_num) && i < 256; i++) t.push_back(emem[i]);
        t.sort();
        return k < t.size() ? t[k] : 32'hdead_beef;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Data <= 0; e_busy <= 0; e_sorted <= 0; e_num <= 0;
        end else begin
            if (En && Wr && Addr < NUM_A) begin emem[Addr[9:2]] <= WrData; e_sorted <= 0; end
            if (En && Wr && Addr == NUM_A) e_num <= WrData;
            if (En && Wr && Addr == STRT_A) begin e_busy <= busy_len; e_sorted <= 1; end
            else if (e_busy > 0) e_busy <= e_busy - 1;
            if (En && !Wr)
                Data <= Addr == STAT_A ? {30'd0, err_mode && !stuck && e_busy == 0, stuck || e_busy > 0}
                      : e_sorted ? kth(int'(Addr[9:2])) : emem[Addr[9:2]];
        end
    end

    initial forever begin
        @(posedge clk); #1;
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // bus and stream monitor, sampled mid-cycle
    logic [63:0] wr_log[$];
    logic [31:0] out_log[$];
    int          en_cnt = 0, stat_rd = 0, done_cnt = 0, ov_cnt = 0;
    logic        prev_rd = 0, hold = 0;
    logic [31:0] held = 0;

    always @(negedge clk) begin
        if (En) en_cnt <= en_cnt + 1;
        if (En && Wr) wr_log.push_back({Addr, WrData});
        if (En && !Wr) check("rd_overlap", 32'(prev_rd), 0);
        if (En && !Wr && Addr == STAT_A) stat_rd <= stat_rd + 1;
        prev_rd <= En && !Wr;
        if (hold) begin
            check("hold_valid", 32'(out_valid), 1);
            check("hold_data", out_data, held);
        end
        hold <= out_valid && !out_ready;
        held <= out_data;
        if (out_valid) ov_cnt <= ov_cnt + 1;
        if (out_valid && out_ready) out_log.push_back(out_data);
        if (job_done) done_cnt <= done_cnt + 1;
    end

    task automatic load_job(input logic [31:0] ins[$], input bit rnd_gap);
        int  sent = 0, cyc = 0;
        bit  hs;
        job_num = 9'(ins.size()); job_start = 1;
        @(posedge clk); #1; job_start = 0;
        check("busy", 32'(job_busy), 1);
        while (sent < ins.size() && cyc < 2000) begin
            in_valid = rnd_gap ? $urandom_range(0, 3) != 0 : 1'b1;
            in_data  = ins[sent];
            @(negedge clk); hs = in_valid && in_ready;
            @(posedge clk); #1;
            if (hs) sent++;
            cyc++;
        end
        in_valid = 0;
        check("load_sent", sent, ins.size());
    endtask

    task automatic run_job(input logic [31:0] ins[$], input bit rnd_gap, input bit exp_err, input bit poke);
        logic [31:0] exp[$];
        int  n = ins.size(), w0 = wr_log.size(), o0 = out_log.size(), d0 = done_cnt, v0 = ov_cnt, cyc = 0;
        bit  done = 0;
        load_job(ins, rnd_gap);
        while (!done && cyc < 5000) begin
            @(negedge clk); done = job_done; cyc++;
            if (poke && cyc == 3) begin job_num = 0; job_start = 1; end
            if (poke && cyc == 4) job_start = 0;
        end
        check("done_seen", 32'(done), 1);
        repeat (3) @(posedge clk);
        #1;
        check("done_pulses", done_cnt - d0, 1);
        check("err", 32'(job_err), 32'(exp_err));
        check("idle", 32'(job_busy), 0);
        exp = ins; exp.sort();
        if (exp_err) check("no_out", ov_cnt - v0, 0);
        else begin
            check("out_count", out_log.size() - o0, n);
            for (int i = 0; i < n && o0 + i < out_log.size(); i++)
                check($sformatf("out%0d", i), out_log[o0+i], exp[i]);
        end
        check("wr_count", wr_log.size() - w0, n + 2);
        for (int i = 0; i < n + 2 && w0 + i < wr_log.size(); i++) begin
            check($sformatf("wr_addr%0d", i), wr_log[w0+i][63:32], i < n ? 32'(4*i) : i == n ? NUM_A : STRT_A);
            check($sformatf("wr_data%0d", i), wr_log[w0+i][31:0], i < n ? ins[i] : i == n ? 32'(n) : 32'h1);
        end
    endtask

    task automatic bad_job(input logic [8:0] num);
        int e0 = en_cnt, d0 = done_cnt;
        job_num = num; job_start = 1;
        @(posedge clk); #1; job_start = 0;
        @(negedge clk);
        check("bad_done", 32'(job_done), 1);
        check("bad_err", 32'(job_err), 1);
        repeat (3) @(posedge clk);
        #1;
        check("bad_en", en_cnt - e0, 0);
        check("bad_pulses", done_cnt - d0, 1);
        check("bad_err_hold", 32'(job_err), 1);
    endtask

    task automatic rand_list(input int n, output logic [31:0] q[$]);
        q = {};
        for (int i = 0; i < n; i++) q.push_back($urandom);
    endtask

    initial begin
        logic [31:0] q[$];
        bit found;
        int s0, cyc;
        #12;
        check("rst_ctl", 32'({En, Wr, in_ready, out_valid, job_busy, job_done, job_err}), 0);
        check("rst_addr", Addr, 0);
        check("rst_odata", out_data, 0);
        reset_n = 1;
        @(posedge clk); #1;

        q = {32'd9, 32'd3, 32'd7, 32'd1};
        run_job(q, 0, 0, 1);
        bad_job(9'd0);
        bad_job(9'd257);
        busy_len = 5;
        rand_list(3, q); rnd_ready = 1;
        run_job(q, 1, 0, 0);
        rnd_ready = 0;
        q = {32'd5}; run_job(q, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            busy_len = $urandom_range(0, 6);
            rand_list($urandom_range(2, 24), q); rnd_ready = $urandom_range(0, 1) == 1;
            run_job(q, 1, 0, 0);
        end
        rnd_ready = 0;
        rand_list(256, q); run_job(q, 0, 0, 0);
        err_mode = 1; busy_len = 3;
        rand_list(3, q); run_job(q, 0, 1, 0);
        err_mode = 0;

        stuck = 1; found = 0;
        rand_list(3, q); load_job(q, 0);
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (En && !Wr && Addr == STAT_A) begin @(negedge clk); found = 1; end
        end
        check("poll_found", 32'(found), 1);
        reset_n = 0; #1;
        check("mid_rst_ctl", 32'({En, Wr, in_ready, out_valid, job_busy, job_done, job_err}), 0);
        check("mid_rst_addr", Addr, 0);
        check("mid_rst_wdata", WrData, 0);
        check("mid_rst_odata", out_data, 0);
        stuck = 0; #2; reset_n = 1;
        @(posedge clk); #1;
        busy_len = 2;
        q = {32'hffff_fff0, 32'h10}; run_job(q, 0, 0, 0);

`ifdef SORT_SEQ_TIMEOUT_EN
        stuck = 1; s0 = stat_rd; found = 0; cyc = 0;
        rand_list(2, q); load_job(q, 0);
        while (!found && cyc < 500) begin @(negedge clk); found = job_done; cyc++; end
        check("to_done", 32'(found), 1);
        repeat (2) @(posedge clk);
        #1;
        check("to_reads", stat_rd - s0, 8);
        check("to_err", 32'(job_err), 1);
        stuck = 0;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
